// File: rtl/cube_pkg.sv
// Shared widths, FSM state encoding and packed-array slicing helpers for the
// facelet colour sampler.
package cube_pkg;

    localparam int NUM_FACELETS = 54;
    localparam int COORD_W      = 10;
    localparam int COLOR_W      = 8;
    localparam int SUM_W        = 12;

    localparam int CUBE_W = NUM_FACELETS * COORD_W;
    localparam int RGB_W  = NUM_FACELETS * COLOR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACCUM,
        S_DONE
    } state_e;

    // Facelet 0 sits in the most-significant field, facelet 53 in the least.
    function automatic int coord_lsb(input int idx);
        return COORD_W * (NUM_FACELETS - 1 - idx);
    endfunction

    function automatic int color_lsb(input int idx);
        return COLOR_W * (NUM_FACELETS - 1 - idx);
    endfunction

    function automatic logic [COORD_W-1:0] coord_at(input logic [CUBE_W-1:0] vec,
                                                    input int idx);
        return vec[coord_lsb(idx) +: COORD_W];
    endfunction

endpackage

// File: rtl/facelet_color_sampler_if.sv
// Pixel stream and capture handshake between the CCD/Bayer path and the
// facelet colour sampler.
interface facelet_color_sampler_if;
    import cube_pkg::*;

    logic               iCapture;
    logic               iFVAL;
    logic               iDVAL;
    logic [COORD_W-1:0] iX;
    logic [COORD_W-1:0] iY;
    logic [COLOR_W-1:0] iR;
    logic [COLOR_W-1:0] iG;
    logic [COLOR_W-1:0] iB;
    logic               oBusy;
    logic               oDone;

    modport master (
        output iCapture, iFVAL, iDVAL, iX, iY, iR, iG, iB,
        input  oBusy, oDone
    );

    modport slave (
        input  iCapture, iFVAL, iDVAL, iX, iY, iR, iG, iB,
        output oBusy, oDone
    );

endinterface

// File: rtl/facelet_accum.sv
// Per-facelet window match and colour accumulation. SAMPLER_AVG_EN selects
// 12-bit window sums; otherwise a single matching pixel is held as-is.
module facelet_accum
    import cube_pkg::*;
#(
    parameter int WIN_LO = 2,
    parameter int WIN_HI = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [COLOR_W-1:0] r_i,
    input  logic [COLOR_W-1:0] g_i,
    input  logic [COLOR_W-1:0] b_i,
    output logic [COLOR_W-1:0] avg_r_o,
    output logic [COLOR_W-1:0] avg_g_o,
    output logic [COLOR_W-1:0] avg_b_o
);

    localparam int DW = COORD_W + 1;
    localparam logic signed [DW-1:0] LO_S = DW'(-WIN_LO);
    localparam logic signed [DW-1:0] HI_S = DW'(WIN_HI);

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic                 hit;

    // Offsets from the centre are signed, so windows near 0 clip instead of wrapping.
    assign dx  = $signed({1'b0, x_i}) - $signed({1'b0, cx_i});
    assign dy  = $signed({1'b0, y_i}) - $signed({1'b0, cy_i});
    assign hit = (dx >= LO_S) && (dx <= HI_S) && (dy >= LO_S) && (dy <= HI_S);

`ifdef SAMPLER_AVG_EN
    logic [SUM_W-1:0] sum_r_q, sum_g_q, sum_b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
        end else if (clr_i) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
        end else if (en_i && hit) begin
            sum_r_q <= sum_r_q + SUM_W'(r_i);
            sum_g_q <= sum_g_q + SUM_W'(g_i);
            sum_b_q <= sum_b_q + SUM_W'(b_i);
        end
    end

    // Fixed divide by the full window area, even when the window is clipped.
    assign avg_r_o = sum_r_q[SUM_W-1 -: COLOR_W];
    assign avg_g_o = sum_g_q[SUM_W-1 -: COLOR_W];
    assign avg_b_o = sum_b_q[SUM_W-1 -: COLOR_W];
`else
    logic [COLOR_W-1:0] hold_r_q, hold_g_q, hold_b_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_r_q <= '0;
            hold_g_q <= '0;
            hold_b_q <= '0;
        end else if (clr_i) begin
            hold_r_q <= '0;
            hold_g_q <= '0;
            hold_b_q <= '0;
        end else if (en_i && hit) begin
            hold_r_q <= r_i;
            hold_g_q <= g_i;
            hold_b_q <= b_i;
        end
    end

    assign avg_r_o = hold_r_q;
    assign avg_g_o = hold_g_q;
    assign avg_b_o = hold_b_q;
`endif

endmodule

// File: rtl/facelet_color_sampler.sv
// One-frame colour capture for all 54 cube facelets: FSM, frame-edge detect,
// coordinate latches and output packing. SAMPLER_AVG_EN enables 4x4 averaging.
module facelet_color_sampler
    import cube_pkg::*;
#(
    parameter int WIN_LOG2 = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    facelet_color_sampler_if.slave pix,
    input  logic [CUBE_W-1:0]      CubeX,
    input  logic [CUBE_W-1:0]      CubeY,
    output logic [RGB_W-1:0]       Color_R,
    output logic [RGB_W-1:0]       Color_G,
    output logic [RGB_W-1:0]       Color_B
);

`ifdef SAMPLER_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif
    // Single-pixel sampling is a 1x1 window centred exactly on the facelet.
    localparam int WIN_SHIFT = AVG_EN ? WIN_LOG2 : 0;
    localparam int WIN_EDGE  = 1 << WIN_SHIFT;
    localparam int WIN_LO    = WIN_EDGE / 2;
    localparam int WIN_HI    = WIN_EDGE - WIN_LO - 1;

    state_e state_q, state_d;
    logic   fval_q;
    logic   done_q;
    logic   fval_rise;
    logic   clr;
    logic   acc_en;

    logic [COORD_W-1:0] cx_q  [NUM_FACELETS];
    logic [COORD_W-1:0] cy_q  [NUM_FACELETS];
    logic [COLOR_W-1:0] r_q   [NUM_FACELETS];
    logic [COLOR_W-1:0] g_q   [NUM_FACELETS];
    logic [COLOR_W-1:0] b_q   [NUM_FACELETS];
    logic [COLOR_W-1:0] avg_r [NUM_FACELETS];
    logic [COLOR_W-1:0] avg_g [NUM_FACELETS];
    logic [COLOR_W-1:0] avg_b [NUM_FACELETS];

    assign fval_rise = pix.iFVAL & ~fval_q;
    assign clr       = (state_q == S_IDLE) & pix.iCapture;
    assign acc_en    = (state_q == S_ACCUM) & pix.iFVAL & pix.iDVAL;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pix.iCapture) state_d = S_ARMED;
            // A frame already in progress on entry is skipped: only a fresh rise counts.
            S_ARMED: if (fval_rise) state_d = S_ACCUM;
            S_ACCUM: if (!pix.iFVAL) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            fval_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fval_q  <= pix.iFVAL;
            done_q  <= (state_q == S_DONE);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NUM_FACELETS; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_FACELETS; i++) begin
                cx_q[i] <= coord_at(CubeX, i);
                cy_q[i] <= coord_at(CubeY, i);
            end
        end
    end

    // All facelets publish together on the DONE edge and hold until the next one.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NUM_FACELETS; i++) begin
                r_q[i] <= '0;
                g_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else if (state_q == S_DONE) begin
            for (int i = 0; i < NUM_FACELETS; i++) begin
                r_q[i] <= avg_r[i];
                g_q[i] <= avg_g[i];
                b_q[i] <= avg_b[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_FACELETS; i++) begin : g_facelet
        facelet_accum #(
            .WIN_LO (WIN_LO),
            .WIN_HI (WIN_HI)
        ) u_accum (
            .clk_i   (iCLK),
            .rst_ni  (iRST_N),
            .clr_i   (clr),
            .en_i    (acc_en),
            .x_i     (pix.iX),
            .y_i     (pix.iY),
            .cx_i    (cx_q[i]),
            .cy_i    (cy_q[i]),
            .r_i     (pix.iR),
            .g_i     (pix.iG),
            .b_i     (pix.iB),
            .avg_r_o (avg_r[i]),
            .avg_g_o (avg_g[i]),
            .avg_b_o (avg_b[i])
        );

        assign Color_R[color_lsb(i) +: COLOR_W] = r_q[i];
        assign Color_G[color_lsb(i) +: COLOR_W] = g_q[i];
        assign Color_B[color_lsb(i) +: COLOR_W] = b_q[i];
    end

    assign pix.oBusy = (state_q != S_IDLE);
    assign pix.oDone = done_q;

endmodule

// File: tb/tb_facelet_color_sampler.sv
// Randomised frame bench for facelet_color_sampler; expected colours come from
// a per-facelet window model evaluated directly on the pixel pattern functions.
module tb_facelet_color_sampler;
    import cube_pkg::*;

    localparam int PAT_UNI   = 0;
    localparam int PAT_RAMP  = 1;
    localparam int PAT_WHITE = 2;
    localparam int PAT_RAND  = 3;

`ifdef SAMPLER_AVG_EN
    localparam logic [7:0] RAMP_F0_EXP  = 8'h63;
    localparam logic [7:0] WHITE_00_EXP = 8'h3F;
`else
    localparam logic [7:0] RAMP_F0_EXP  = 8'h64;
    localparam logic [7:0] WHITE_00_EXP = 8'hFF;
`endif

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b1;
    logic [CUBE_W-1:0] CubeX, CubeY;
    logic [RGB_W-1:0]  Color_R, Color_G, Color_B;

    facelet_color_sampler_if pix();

    facelet_color_sampler dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .pix     (pix),
        .CubeX   (CubeX),
        .CubeY   (CubeY),
        .Color_R (Color_R),
        .Color_G (Color_G),
        .Color_B (Color_B)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int cur_x [NUM_FACELETS];
    int cur_y [NUM_FACELETS];
    int lat_x [NUM_FACELETS];
    int lat_y [NUM_FACELETS];

    always @(negedge iCLK) if (pix.oDone === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [RGB_W-1:0] got,
                         input logic [RGB_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [7:0] model_px(input int pat, input int seed,
                                            input int x, input int y, input int ch);
        int unsigned hsh;
        case (pat)
            PAT_UNI:   return (ch == 0) ? 8'h40 : (ch == 1) ? 8'h80 : 8'hC0;
            PAT_RAMP:  return (ch == 0) ? 8'(x) : (ch == 1) ? 8'(y) : 8'(x + y);
            PAT_WHITE: return 8'hFF;
            default: begin
                hsh = (x * 131 + y * 7919 + ch * 104729 + seed) * 32'h9E3779B1;
                return hsh[23:16];
            end
        endcase
    endfunction

    // Expected published colours for the frame, from the latched facelet centres.
    task automatic model_frame(input int w, input int h, input int pat, input int seed,
                               output logic [RGB_W-1:0] er, output logic [RGB_W-1:0] eg,
                               output logic [RGB_W-1:0] eb);
        int v;
        int x;
        int y;
        logic [7:0] b;
        er = '0; eg = '0; eb = '0;
        for (int i = 0; i < NUM_FACELETS; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                v = 0;
`ifdef SAMPLER_AVG_EN
                for (int dy = -2; dy <= 1; dy++) begin
                    for (int dx = -2; dx <= 1; dx++) begin
                        x = lat_x[i] + dx;
                        y = lat_y[i] + dy;
                        if (x >= 0 && x < w && y >= 0 && y < h)
                            v += int'(model_px(pat, seed, x, y, ch));
                    end
                end
                v = v / 16;
`else
                x = lat_x[i];
                y = lat_y[i];
                if (x < w && y < h) v = int'(model_px(pat, seed, x, y, ch));
`endif
                b = 8'(v);
                if (ch == 0) er[8*(NUM_FACELETS-1-i) +: 8] = b;
                else if (ch == 1) eg[8*(NUM_FACELETS-1-i) +: 8] = b;
                else eb[8*(NUM_FACELETS-1-i) +: 8] = b;
            end
        end
    endtask

    task automatic drive_coords();
        for (int i = 0; i < NUM_FACELETS; i++) begin
            CubeX[COORD_W*(NUM_FACELETS-1-i) +: COORD_W] = COORD_W'(cur_x[i]);
            CubeY[COORD_W*(NUM_FACELETS-1-i) +: COORD_W] = COORD_W'(cur_y[i]);
        end
    endtask

    task automatic rand_coords(input int w, input int h);
        for (int i = 0; i < NUM_FACELETS; i++) begin
            cur_x[i] = $urandom_range(0, w + 2);
            cur_y[i] = $urandom_range(0, h + 2);
        end
        drive_coords();
    endtask

    task automatic capture();
        pix.iCapture = 1'b1;
        lat_x = cur_x;
        lat_y = cur_y;
        tick();
        pix.iCapture = 1'b0;
        check("busy_rise", RGB_W'(pix.oBusy), RGB_W'(1'b1));
    endtask

    task automatic rand_bus();
        pix.iDVAL = 1'b0;
        pix.iX = COORD_W'($urandom);
        pix.iY = COORD_W'($urandom);
        pix.iR = 8'($urandom);
        pix.iG = 8'($urandom);
        pix.iB = 8'($urandom);
    endtask

    task automatic send_frame(input string name, input int w, input int h, input int pat,
                              input int seed, input int cap_at, input int cap2_at,
                              input int abort_at, input bit exp_done);
        int idx;
        int d0;
        logic [RGB_W-1:0] er, eg, eb;
        idx = 0;
        d0  = done_cnt;
        pix.iFVAL = 1'b1;
        rand_bus();
        tick();
        tick();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rand_bus();
                    tick();
                end
                pix.iDVAL = 1'b1;
                pix.iX = COORD_W'(x);
                pix.iY = COORD_W'(y);
                pix.iR = model_px(pat, seed, x, y, 0);
                pix.iG = model_px(pat, seed, x, y, 1);
                pix.iB = model_px(pat, seed, x, y, 2);
                pix.iCapture = (idx == cap_at) || (idx == cap2_at);
                if (idx == cap_at) begin
                    lat_x = cur_x;
                    lat_y = cur_y;
                end
                if (idx == cap2_at) rand_coords(w, h);
                tick();
                pix.iCapture = 1'b0;
                if (idx == abort_at) begin
                    #3 iRST_N = 1'b0;
                    #1;
                    check({name, "_rst_R"}, Color_R, '0);
                    check({name, "_rst_G"}, Color_G, '0);
                    check({name, "_rst_B"}, Color_B, '0);
                    check({name, "_rst_busy"}, RGB_W'(pix.oBusy), '0);
                    check({name, "_rst_done"}, RGB_W'(pix.oDone), '0);
                    pix.iFVAL = 1'b0;
                    rand_bus();
                    tick();
                    tick();
                    iRST_N = 1'b1;
                    tick();
                    return;
                end
                idx++;
            end
        end
        pix.iFVAL = 1'b0;
        rand_bus();
        tick();
        if (exp_done) begin
            check({name, "_done_early"}, RGB_W'(pix.oDone), '0);
            check({name, "_busy_hold"}, RGB_W'(pix.oBusy), RGB_W'(1'b1));
            tick();
            model_frame(w, h, pat, seed, er, eg, eb);
            check({name, "_done_pulse"}, RGB_W'(pix.oDone), RGB_W'(1'b1));
            check({name, "_busy_fall"}, RGB_W'(pix.oBusy), '0);
            check({name, "_R"}, Color_R, er);
            check({name, "_G"}, Color_G, eg);
            check({name, "_B"}, Color_B, eb);
            tick();
            check({name, "_done_width"}, RGB_W'(pix.oDone), '0);
            check({name, "_done_count"}, RGB_W'(done_cnt - d0), RGB_W'(1));
        end else begin
            tick();
            tick();
            check({name, "_no_done"}, RGB_W'(done_cnt - d0), '0);
        end
    endtask

    initial begin
        pix.iCapture = 1'b0;
        pix.iFVAL    = 1'b0;
        rand_bus();
        for (int i = 0; i < NUM_FACELETS; i++) begin
            cur_x[i] = 0;
            cur_y[i] = 0;
        end
        drive_coords();

        #2 iRST_N = 1'b0;
        #1;
        check("reset_R", Color_R, '0);
        check("reset_G", Color_G, '0);
        check("reset_B", Color_B, '0);
        check("reset_busy", RGB_W'(pix.oBusy), '0);
        check("reset_done", RGB_W'(pix.oDone), '0);
        tick();
        tick();
        iRST_N = 1'b1;
        tick();

        // Uniform frame, facelets on a 9x6 interior grid.
        for (int i = 0; i < NUM_FACELETS; i++) begin
            cur_x[i] = 4 + 4 * (i % 9);
            cur_y[i] = 4 + 4 * (i / 9);
        end
        drive_coords();
        capture();
        send_frame("uni", 44, 32, PAT_UNI, 0, -1, -1, -1, 1'b1);
        check("uni_R_all", Color_R, {NUM_FACELETS{8'h40}});
        check("uni_G_all", Color_G, {NUM_FACELETS{8'h80}});
        check("uni_B_all", Color_B, {NUM_FACELETS{8'hC0}});

        // Horizontal ramp with facelet 0 at (100,50).
        rand_coords(112, 56);
        cur_x[0] = 100;
        cur_y[0] = 50;
        drive_coords();
        capture();
        send_frame("ramp", 112, 56, PAT_RAMP, 0, -1, -1, -1, 1'b1);
        check("ramp_f0_R", RGB_W'(Color_R[431:424]), RGB_W'(RAMP_F0_EXP));

        // White frame with facelet 53 in the corner.
        rand_coords(40, 24);
        cur_x[53] = 0;
        cur_y[53] = 0;
        drive_coords();
        capture();
        send_frame("white", 40, 24, PAT_WHITE, 0, -1, -1, -1, 1'b1);
        check("white_f53_R", RGB_W'(Color_R[7:0]), RGB_W'(WHITE_00_EXP));

        // Capture mid-frame: skip it, take the next; a second request is ignored.
        rand_coords(40, 24);
        send_frame("skip", 40, 24, PAT_RAND, int'($urandom), 100, -1, -1, 1'b0);
        check("skip_armed_busy", RGB_W'(pix.oBusy), RGB_W'(1'b1));
        send_frame("next", 40, 24, PAT_RAND, int'($urandom), -1, 200, -1, 1'b1);

        // Reset in the middle of accumulation, then a clean capture.
        rand_coords(40, 24);
        capture();
        send_frame("abort", 40, 24, PAT_RAND, int'($urandom), -1, -1, 300, 1'b0);
        rand_coords(40, 24);
        capture();
        send_frame("fresh", 40, 24, PAT_RAND, int'($urandom), -1, -1, -1, 1'b1);

        for (int n = 0; n < 3; n++) begin
            int w;
            int h;
            w = $urandom_range(16, 64);
            h = $urandom_range(12, 40);
            rand_coords(w, h);
            capture();
            send_frame("rnd", w, h, $urandom_range(1, 3), int'($urandom), -1, -1, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
